exp_time_ctrl: RTL and testbench
================================

# exp_time_ctrl

Parametrised exposure-time controller and exposure timer for the camera control path. It holds the current exposure setting, adjusted by debounced-edge increase/decrease keys with saturation and optional hold-to-repeat. On a start request it runs a cycle-exact exposure window of the latched setting, then reports completion. It sits between the button/keypad front end and the sensor-control FSM, replacing the fixed-range 5-bit exposure register.

## Interface
- WIDTH, 5: bit width of Exp_Time.
- EXP_MIN, 2: lowest exposure setting in units (ms).
- EXP_MAX, 30: highest exposure setting in units; EXP_MIN ≤ EXP_INIT ≤ EXP_MAX < 2^WIDTH.
- EXP_INIT, 15: setting after reset.
- EXP_STEP, 1: units added/subtracted per adjust event.
- TICKS_PER_UNIT, 1000: Clk cycles per unit (1 ms at 1 MHz).
- REPEAT_DELAY, 500: cycles a key must be held before the first auto-repeat.
- REPEAT_PERIOD, 100: cycles between subsequent auto-repeats.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Exp_Increase  in  1  level, high while key held; synchronous to Clk.
- Exp_Decrease  in  1  level, high while key held; synchronous to Clk.
- Exp_Start  in  1  single-cycle exposure request.
- Exp_Abort  in  1  single-cycle abort request.
- Exp_Time  out  WIDTH  current exposure setting.
- Exp_Busy  out  1  high from the first exposing cycle through the Done cycle.
- Exposing  out  1  sensor integrate enable.
- Exp_Done  out  1  one-cycle completion pulse.

## Operation
- Reset values: Exp_Time=EXP_INIT, Exp_Busy=0, Exposing=0, Exp_Done=0, FSM=IDLE, all counters 0.
- Adjust event: a rising edge of a key, i.e. the key is high now and was low the previous cycle. With auto-repeat, repeat ticks also count as adjust events.
- Increase: Exp_Time ← min(Exp_Time+EXP_STEP, EXP_MAX).
- Decrease: Exp_Time ← max(Exp_Time−EXP_STEP, EXP_MIN).
- Arithmetic is done in WIDTH+1 bits so it never wraps.
- Both keys' events in the same cycle: no change. Neither key's repeat timer restarts.
- Adjust events are applied only in IDLE. Events in any other state are discarded, not queued.
- FSM states:
  - IDLE, on Exp_Start → EXPOSE. Exp_Time is latched into Lat_Time and the tick counter loads Lat_Time×TICKS_PER_UNIT−1.
  - EXPOSE: Exposing=1, Exp_Busy=1. The counter decrements each cycle; at 0 → DONE.
  - DONE: Exp_Done=1, Exp_Busy=1, Exposing=0; → IDLE next cycle.
- Exp_Abort in EXPOSE → IDLE next cycle, with no Exp_Done. Exp_Abort in IDLE or DONE is ignored.
- Exp_Start outside IDLE is ignored. Exp_Start and Exp_Abort together in IDLE: start wins.
- Exp_Start and a key event in the same IDLE cycle: the latch takes the pre-adjust value, and the adjustment is discarded.
- Reset_n low in any state: immediate return to reset values, asynchronously.

## Timing
- Adjust latency: Exp_Time updates on the clock edge after the cycle in which the key is first sampled high.
- Exposure: Exp_Start sampled at edge k. Exposing is high for exactly Lat_Time×TICKS_PER_UNIT cycles, starting at edge k+1. Exp_Done is high for one cycle immediately after. Exp_Busy falls together with Exp_Done.
- Back-to-back: the earliest next accepted Exp_Start is the cycle after DONE.
- Tick counter width: $clog2(EXP_MAX×TICKS_PER_UNIT+1).

## Configuration
- EXP_AUTO_REPEAT_EN defined: a key held continuously produces its first repeat event REPEAT_DELAY cycles after its edge event, then one every REPEAT_PERIOD cycles. Releasing the key clears its repeat counter.
- EXP_AUTO_REPEAT_EN undefined: edge events only. No repeat counters are synthesised, and REPEAT_* parameters are unused.

## Structure
- Shared package exp_pkg holds the FSM state typedef (IDLE, EXPOSE, DONE) and the default-value constants EXP_MIN_D, EXP_MAX_D and EXP_INIT_D.
- Sub-module exp_key_repeat, instantiated once per key, contains the edge detector plus the repeat counter under EXP_AUTO_REPEAT_EN. Its outputs are a single-cycle Key_Event pulse.

## Test plan
- Reset then 20 single Exp_Increase pulses → Exp_Time reaches 30 after 15 pulses and stays at 30. 30 Exp_Decrease pulses → stops at 2.
- Hold Exp_Increase for 1000 cycles with auto-repeat on (defaults) → events at cycles 1, 501, 601, 701, 801, 901; Exp_Time goes 15→21. With the macro off → 16.
- Both keys rise in the same cycle → Exp_Time unchanged.
- Exp_Time=3, TICKS_PER_UNIT=4, Exp_Start pulse → Exposing high for exactly 12 cycles, then one Exp_Done cycle. Exp_Busy is high for 13 cycles. A key press mid-exposure leaves Exp_Time at 3.
- Exp_Abort on the 5th Exposing cycle → Exposing and Exp_Busy low next cycle, and no Exp_Done. A subsequent Exp_Start runs a full 12-cycle window.
- Reset_n asserted mid-EXPOSE → all outputs return to reset values before the next Clk edge, and Exp_Time=15.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared types and default settings for the exposure-time controller.
package exp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPOSE = 2'd1,
    DONE   = 2'd2
  } exp_state_t;

  localparam int EXP_MIN_D  = 2;
  localparam int EXP_MAX_D  = 30;
  localparam int EXP_INIT_D = 15;

endpackage

// File: rtl/exp_key_repeat.sv
// Per-key rising-edge detector; with EXP_AUTO_REPEAT_EN it also emits
// hold-to-repeat events (first after REPEAT_DELAY, then every REPEAT_PERIOD).
module exp_key_repeat
  import exp_pkg::*;
`ifdef EXP_AUTO_REPEAT_EN
#(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
)
`endif
(
  input  logic Clk,
  input  logic Reset_n,
  input  logic Key,
  output logic Key_Event
);

  logic key_q;
  logic edge_ev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) key_q <= 1'b0;
    else          key_q <= Key;
  end

  assign edge_ev = Key & ~key_q;

`ifdef EXP_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;
  logic          rpt_ev;

  // rpt_cnt is 0 on the edge cycle, so the first repeat lands REPEAT_DELAY cycles later
  assign rpt_ev = Key & key_q &
                  (rpt_cnt == (rpt_phase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (!Key) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_ev) begin
      rpt_cnt   <= RW'(1);
      rpt_phase <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end

  assign Key_Event = edge_ev | rpt_ev;
`else
  assign Key_Event = edge_ev;
`endif

endmodule

// File: rtl/exp_time_ctrl.sv
// Exposure setting register with saturating key adjust plus a cycle-exact
// exposure timer. Optional hold-to-repeat keys: define EXP_AUTO_REPEAT_EN.
module exp_time_ctrl
  import exp_pkg::*;
#(
  parameter int WIDTH          = 5,
  parameter int EXP_MIN        = EXP_MIN_D,
  parameter int EXP_MAX        = EXP_MAX_D,
  parameter int EXP_INIT       = EXP_INIT_D,
  parameter int EXP_STEP       = 1,
  parameter int TICKS_PER_UNIT = 1000,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Exp_Increase,
  input  logic             Exp_Decrease,
  input  logic             Exp_Start,
  input  logic             Exp_Abort,
  output logic [WIDTH-1:0] Exp_Time,
  output logic             Exp_Busy,
  output logic             Exposing,
  output logic             Exp_Done
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(EXP_MAX * TICKS_PER_UNIT + 1);

  if (!(EXP_MIN <= EXP_INIT && EXP_INIT <= EXP_MAX && EXP_MAX < (1 << WIDTH) &&
        EXP_STEP > 0 && TICKS_PER_UNIT > 0 && REPEAT_DELAY > 0 && REPEAT_PERIOD > 0))
  begin : g_bad_param
    $error("exp_time_ctrl: inconsistent parameters");
  end

  logic [1:0] keys, key_ev;
  assign keys = {Exp_Decrease, Exp_Increase};

  for (genvar i = 0; i < 2; i++) begin : g_key
    exp_key_repeat
`ifdef EXP_AUTO_REPEAT_EN
      #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
`endif
      u_key (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Key       (keys[i]),
        .Key_Event (key_ev[i])
      );
  end

  exp_state_t       state, state_nxt;
  logic [CW-1:0]    tick_cnt;
  logic [WIDTH-1:0] exp_time;
  logic [W1-1:0]    inc_val;
  logic [WIDTH-1:0] dec_val;
  logic             adj_ok;

  // A start in the same cycle latches the pre-adjust value and drops the key event
  assign adj_ok  = (state == IDLE) && !Exp_Start;
  assign inc_val = {1'b0, exp_time} + W1'(EXP_STEP);
  assign dec_val = ({1'b0, exp_time} < W1'(EXP_MIN + EXP_STEP)) ? WIDTH'(EXP_MIN)
                                                                : exp_time - WIDTH'(EXP_STEP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      exp_time <= WIDTH'(EXP_INIT);
    end else if (adj_ok) begin
      case (key_ev)
        2'b01:   exp_time <= (inc_val > W1'(EXP_MAX)) ? WIDTH'(EXP_MAX) : inc_val[WIDTH-1:0];
        2'b10:   exp_time <= dec_val;
        default: exp_time <= exp_time;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Exp_Start) state_nxt = EXPOSE;
      EXPOSE:  if (Exp_Abort) state_nxt = IDLE;
               else if (tick_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loaded with N-1 so the EXPOSE state lasts exactly N cycles
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      tick_cnt <= '0;
    else if (state == IDLE && Exp_Start)
      tick_cnt <= CW'(32'(exp_time) * TICKS_PER_UNIT - 1);
    else if (state == EXPOSE && !Exp_Abort && tick_cnt != '0)
      tick_cnt <= tick_cnt - 1'b1;
    else
      tick_cnt <= '0;
  end

  assign Exp_Time = exp_time;
  assign Exposing = (state == EXPOSE);
  assign Exp_Busy = (state != IDLE);
  assign Exp_Done = (state == DONE);

endmodule

// File: tb/tb_exp_time_ctrl.sv
// Directed self-checking bench for exp_time_ctrl (TICKS_PER_UNIT=4).
module tb_exp_time_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Exp_Increase = 1'b0, Exp_Decrease = 1'b0;
  logic       Exp_Start = 1'b0, Exp_Abort = 1'b0;
  logic [4:0] Exp_Time;
  logic       Exp_Busy, Exposing, Exp_Done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef EXP_AUTO_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  exp_time_ctrl #(.TICKS_PER_UNIT(4)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Exp_Increase (Exp_Increase),
    .Exp_Decrease (Exp_Decrease),
    .Exp_Start    (Exp_Start),
    .Exp_Abort    (Exp_Abort),
    .Exp_Time     (Exp_Time),
    .Exp_Busy     (Exp_Busy),
    .Exposing     (Exposing),
    .Exp_Done     (Exp_Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    tick;
    tick;
    Reset_n = 1'b1;
    tick;
  endtask

  task automatic pulse_key(input bit inc);
    if (inc) Exp_Increase = 1'b1;
    else     Exp_Decrease = 1'b1;
    tick;
    Exp_Increase = 1'b0;
    Exp_Decrease = 1'b0;
    tick;
  endtask

  // Samples 30 cycles starting right after the start edge; index 0 = first exposing cycle.
  task automatic run_window(output int n_exp, output int n_busy, output int n_done,
                            output int first_done, output int last_exp);
    n_exp = 0; n_busy = 0; n_done = 0; first_done = -1; last_exp = -1;
    for (int i = 0; i < 30; i++) begin
      if (Exposing) begin n_exp++; last_exp = i; end
      if (Exp_Busy) n_busy++;
      if (Exp_Done) begin n_done++; if (first_done < 0) first_done = i; end
      tick;
    end
  endtask

  task automatic test_reset;
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (Exp_Time !== 5'd15 || Exp_Busy !== 1'b0 || Exposing !== 1'b0 || Exp_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: time=%0d busy=%b exp=%b done=%b want 15/0/0/0",
               Exp_Time, Exp_Busy, Exposing, Exp_Done);
    end
    tick;
    Reset_n = 1'b1;
    tick;
  endtask

  task automatic test_increase_sat;
    logic [4:0] e;
    for (int i = 1; i <= 20; i++) begin
      pulse_key(1'b1);
      e = 5'((15 + i > 30) ? 30 : 15 + i);
      n_checks++;
      if (Exp_Time !== e) begin
        n_fail++;
        $display("FAIL inc_sat pulse %0d: got %0d want %0d", i, Exp_Time, e);
      end
    end
  endtask

  task automatic test_decrease_sat;
    logic [4:0] e;
    for (int i = 1; i <= 30; i++) begin
      pulse_key(1'b0);
      e = 5'((30 - i < 2) ? 2 : 30 - i);
      n_checks++;
      if (Exp_Time !== e) begin
        n_fail++;
        $display("FAIL dec_sat pulse %0d: got %0d want %0d", i, Exp_Time, e);
      end
    end
  endtask

  task automatic test_both_keys;
    pulse_key(1'b1);
    n_checks++;
    if (Exp_Time !== 5'd3) begin
      n_fail++; $display("FAIL both_pre: got %0d want 3", Exp_Time);
    end
    Exp_Increase = 1'b1;
    Exp_Decrease = 1'b1;
    tick;
    n_checks++;
    if (Exp_Time !== 5'd3) begin
      n_fail++; $display("FAIL both_keys: got %0d want 3", Exp_Time);
    end
    Exp_Increase = 1'b0;
    Exp_Decrease = 1'b0;
    tick;
  endtask

  task automatic test_auto_repeat;
    logic [4:0] e;
    do_reset;
    Exp_Increase = 1'b1;
    tick;
    n_checks++;
    if (Exp_Time !== 5'd16) begin
      n_fail++; $display("FAIL hold_edge: got %0d want 16", Exp_Time);
    end
    repeat (499) tick;
    n_checks++;
    if (Exp_Time !== 5'd16) begin
      n_fail++; $display("FAIL hold_500: got %0d want 16", Exp_Time);
    end
    tick;
    e = 5'(16 + REP_ON);
    n_checks++;
    if (Exp_Time !== e) begin
      n_fail++; $display("FAIL hold_501: got %0d want %0d", Exp_Time, e);
    end
    repeat (499) tick;
    e = 5'(16 + 5 * REP_ON);
    n_checks++;
    if (Exp_Time !== e) begin
      n_fail++; $display("FAIL hold_1000: got %0d want %0d", Exp_Time, e);
    end
    Exp_Increase = 1'b0;
    tick;
    pulse_key(1'b1);
    e = 5'(17 + 5 * REP_ON);
    n_checks++;
    if (Exp_Time !== e) begin
      n_fail++; $display("FAIL hold_repress: got %0d want %0d", Exp_Time, e);
    end
  endtask

  task automatic test_exposure;
    int n_exp, n_busy, n_done, first_done, last_exp;
    do_reset;
    repeat (12) pulse_key(1'b0);
    n_checks++;
    if (Exp_Time !== 5'd3) begin
      n_fail++; $display("FAIL expo_setup: got %0d want 3", Exp_Time);
    end
    Exp_Start = 1'b1;
    tick;
    Exp_Start = 1'b0;
    n_exp = 0; n_busy = 0; n_done = 0; first_done = -1; last_exp = -1;
    for (int i = 0; i < 30; i++) begin
      if (Exposing) begin n_exp++; last_exp = i; end
      if (Exp_Busy) n_busy++;
      if (Exp_Done) begin n_done++; if (first_done < 0) first_done = i; end
      Exp_Start    = (i == 2);
      Exp_Increase = (i == 4);
      tick;
    end
    Exp_Start = 1'b0;
    Exp_Increase = 1'b0;
    n_checks++;
    if (n_exp !== 12 || last_exp !== 11) begin
      n_fail++; $display("FAIL expo_len: got %0d (last %0d) want 12 (last 11)", n_exp, last_exp);
    end
    n_checks++;
    if (n_busy !== 13) begin
      n_fail++; $display("FAIL expo_busy: got %0d want 13", n_busy);
    end
    n_checks++;
    if (n_done !== 1 || first_done !== 12) begin
      n_fail++; $display("FAIL expo_done: got %0d at %0d want 1 at 12", n_done, first_done);
    end
    n_checks++;
    if (Exp_Time !== 5'd3) begin
      n_fail++; $display("FAIL expo_key_ignored: got %0d want 3", Exp_Time);
    end
  endtask

  task automatic test_abort;
    int n_exp, n_busy, n_done, first_done, last_exp;
    logic exp5, busy5;
    Exp_Start = 1'b1;
    tick;
    Exp_Start = 1'b0;
    n_exp = 0; n_done = 0; exp5 = 1'bx; busy5 = 1'bx;
    for (int i = 0; i < 30; i++) begin
      if (Exposing) n_exp++;
      if (Exp_Done) n_done++;
      if (i == 5) begin exp5 = Exposing; busy5 = Exp_Busy; end
      Exp_Abort = (i == 4);
      tick;
    end
    Exp_Abort = 1'b0;
    n_checks++;
    if (exp5 !== 1'b0 || busy5 !== 1'b0) begin
      n_fail++; $display("FAIL abort_stop: exp=%b busy=%b want 0/0", exp5, busy5);
    end
    n_checks++;
    if (n_exp !== 5 || n_done !== 0) begin
      n_fail++; $display("FAIL abort_no_done: exp=%0d done=%0d want 5/0", n_exp, n_done);
    end
    Exp_Start = 1'b1;
    Exp_Abort = 1'b1;
    tick;
    Exp_Start = 1'b0;
    Exp_Abort = 1'b0;
    run_window(n_exp, n_busy, n_done, first_done, last_exp);
    n_checks++;
    if (n_exp !== 12 || n_busy !== 13 || n_done !== 1 || first_done !== 12) begin
      n_fail++;
      $display("FAIL abort_restart: exp=%0d busy=%0d done=%0d@%0d want 12/13/1@12",
               n_exp, n_busy, n_done, first_done);
    end
  endtask

  task automatic test_back_to_back;
    int n_exp, n_busy, n_done, first_done, last_exp;
    Exp_Start = 1'b1;
    tick;
    Exp_Start = 1'b0;
    repeat (12) tick;
    n_checks++;
    if (Exp_Done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: got %b want 1", Exp_Done);
    end
    Exp_Start = 1'b1;
    tick;
    Exp_Start = 1'b0;
    n_checks++;
    if (Exposing !== 1'b0 || Exp_Busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_in_done: exp=%b busy=%b want 0/0", Exposing, Exp_Busy);
    end
    Exp_Start = 1'b1;
    tick;
    Exp_Start = 1'b0;
    run_window(n_exp, n_busy, n_done, first_done, last_exp);
    n_checks++;
    if (n_exp !== 12 || n_done !== 1 || first_done !== 12) begin
      n_fail++;
      $display("FAIL b2b_next: exp=%0d done=%0d@%0d want 12/1@12", n_exp, n_done, first_done);
    end
  endtask

  task automatic test_start_with_key;
    int n_exp, n_busy, n_done, first_done, last_exp;
    Exp_Start = 1'b1;
    Exp_Increase = 1'b1;
    tick;
    Exp_Start = 1'b0;
    Exp_Increase = 1'b0;
    run_window(n_exp, n_busy, n_done, first_done, last_exp);
    n_checks++;
    if (n_exp !== 12 || Exp_Time !== 5'd3) begin
      n_fail++;
      $display("FAIL start_key: exp=%0d time=%0d want 12/3", n_exp, Exp_Time);
    end
  endtask

  task automatic test_reset_mid;
    Exp_Start = 1'b1;
    tick;
    Exp_Start = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (Exposing !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: exp=%b want 1", Exposing);
    end
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if (Exp_Time !== 5'd15 || Exp_Busy !== 1'b0 || Exposing !== 1'b0 || Exp_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: time=%0d busy=%b exp=%b done=%b want 15/0/0/0",
               Exp_Time, Exp_Busy, Exposing, Exp_Done);
    end
    tick;
    Reset_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_increase_sat;
    test_decrease_sat;
    test_both_keys;
    test_auto_repeat;
    test_exposure;
    test_abort;
    test_back_to_back;
    test_start_with_key;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
